// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for simple_uart and its receiver
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam logic [3:0]  FRAME_BITS = 4'd10;
    localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

    // Divider values below 2 would leave no room for a mid-bit sample.
    function automatic logic [31:0] bit_period(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchroniser and a one-byte buffer
//   clk, rst  system clock, synchronous active-high reset
//   ser_rx    asynchronous serial input, idle high
//   period    clocks per serial bit (already clamped to >= 2)
//   rd        read strobe; clears valid on the next edge
//   valid     buffer holds an unread byte
//   data      last received byte
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_rx,
    input  logic [31:0] period,
    input  logic        rd,
    output logic        valid,
    output logic [7:0]  data
);

    logic [1:0] sync;
    logic       rx;
    rx_state_t  state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [2:0] bitn, bitn_n;
    logic [7:0] shift, shift_n;
    logic       hold, hold_n;
    logic       store;

    assign rx = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
            hold  <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            sync  <= {sync[0], ser_rx};
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            shift <= shift_n;
            hold  <= hold_n;
            // A byte completing alongside a read wins over the read.
            valid <= store ? 1'b1 : (rd ? 1'b0 : valid);
            data  <= store ? shift : data;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 32'd1;
        bitn_n  = bitn;
        shift_n = shift;
        hold_n  = hold;
        store   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                // After a framing error the line must return high before re-arming.
                hold_n  = hold && !rx;
                state_n = (!hold && !rx) ? START : IDLE;
            end
            START: begin
                if (cnt == (period >> 1)) begin
                    state_n = rx ? IDLE : DATA;
                    cnt_n   = '0;
                    bitn_n  = '0;
                end
            end
            DATA: begin
                if (cnt == period - 32'd1) begin
                    cnt_n   = '0;
                    shift_n = {rx, shift[7:1]};
                    bitn_n  = bitn + 3'd1;
                    state_n = (bitn == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (cnt == period - 32'd1) begin
                    state_n = IDLE;
                    store   = rx;
                    hold_n  = !rx;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/simple_uart.sv
// simple_uart: memory-mapped 8N1 UART with divider and data registers
//   clk, rst      system clock, synchronous active-high reset
//   ser_tx        serial output, idle high
//   ser_rx        serial input, asynchronous, idle high
//   reg_div_we    byte-lane write strobes for the divider
//   reg_div_di    divider write data
//   reg_div_do    current divider value
//   reg_dat_we    write TX byte from reg_dat_di[7:0]
//   reg_dat_re    read strobe; consumes the RX buffer
//   reg_dat_di    TX data
//   reg_dat_do    received byte, or all ones when the buffer is empty
//   reg_dat_wait  stall while a TX write meets a busy transmitter
module simple_uart
    import uart_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DIV = 32'd16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ser_tx,
    input  logic        ser_rx,
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait
);

    logic [31:0] div;
    logic [31:0] period;
    logic [9:0]  tx_shift;
    logic [3:0]  tx_bits;
    logic [31:0] tx_cnt;
    logic        busy;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        unused_di;

    assign period       = bit_period(div);
    assign busy         = tx_bits != 4'd0;
    assign ser_tx       = tx_shift[0];
    assign reg_dat_wait = reg_dat_we && busy;
    assign reg_div_do   = div;
    assign reg_dat_do   = rx_valid ? {24'h0, rx_byte} : EMPTY_READ;
    assign unused_di    = ^reg_dat_di[31:8];

    // A dummy frame is an all-ones shift register: ten idle bits on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= DEFAULT_DIV;
            tx_shift <= '1;
            tx_bits  <= FRAME_BITS;
            tx_cnt   <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (reg_div_we[i]) div[8*i +: 8] <= reg_div_di[8*i +: 8];
            if (reg_dat_we && !busy) begin
                tx_shift <= {1'b1, reg_dat_di[7:0], 1'b0};
                tx_bits  <= FRAME_BITS;
                tx_cnt   <= '0;
            end else if (|reg_div_we) begin
                tx_shift <= '1;
                tx_bits  <= FRAME_BITS;
                tx_cnt   <= '0;
            end else if (busy) begin
                if (tx_cnt == period - 32'd1) begin
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_bits  <= tx_bits - 4'd1;
                    tx_cnt   <= '0;
                end else begin
                    tx_cnt <= tx_cnt + 32'd1;
                end
            end
        end
    end

    uart_rx u_rx (
        .clk    (clk),
        .rst    (rst),
        .ser_rx (ser_rx),
        .period (period),
        .rd     (reg_dat_re),
        .valid  (rx_valid),
        .data   (rx_byte)
    );

endmodule

// File: tb/tb_simple_uart.sv
// tb_simple_uart: randomized self-checking bench for simple_uart
module tb_simple_uart;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_tx;
    logic        ser_rx = 1'b1;
    logic [3:0]  reg_div_we = '0;
    logic [31:0] reg_div_di = '0;
    logic [31:0] reg_div_do;
    logic        reg_dat_we = 1'b0;
    logic        reg_dat_re = 1'b0;
    logic [31:0] reg_dat_di = '0;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    int checks = 0;
    int passed = 0;

    logic [31:0] m_div;
    logic        m_valid;
    logic [7:0]  m_byte;

    always #5 clk = ~clk;

    simple_uart dut (
        .clk          (clk),
        .rst          (rst),
        .ser_tx       (ser_tx),
        .ser_rx       (ser_rx),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_div_do   (reg_div_do),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int per();
        return (m_div < 2) ? 2 : int'(m_div);
    endfunction

    function automatic logic [31:0] exp_dat();
        return m_valid ? {24'h0, m_byte} : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that started a frame; the host keeps
    // reg_dat_we high throughout and must be stalled until the stop bit ends.
    task automatic watch_tx(input logic [9:0] frame);
        int p;
        p = per();
        reg_dat_we = 1'b1;
        reg_dat_di = $urandom();
        #1;
        for (int s = 0; s < 10 * p; s++) begin
            check("tx_line", 32'(ser_tx), 32'(frame[s / p]));
            check("tx_wait_busy", 32'(reg_dat_wait), 32'd1);
            tick();
        end
        check("tx_wait_done", 32'(reg_dat_wait), 32'd0);
        check("tx_idle", 32'(ser_tx), 32'd1);
        reg_dat_we = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        reg_dat_we = 1'b1;
        reg_dat_di = ($urandom() & 32'hFFFF_FF00) | 32'(b);
        #1;
        check("tx_accept_wait", 32'(reg_dat_wait), 32'd0);
        tick();
        reg_dat_we = 1'b0;
        watch_tx({1'b1, b, 1'b0});
    endtask

    task automatic write_div(input logic [3:0] we, input logic [31:0] val);
        reg_div_we = we;
        reg_div_di = val;
        for (int i = 0; i < 4; i++)
            if (we[i]) m_div[8*i +: 8] = val[8*i +: 8];
        tick();
        reg_div_we = '0;
        check("div_readback", reg_div_do, m_div);
        watch_tx(10'h3FF);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        int p;
        p = per();
        ser_rx = 1'b0;
        repeat (p) tick();
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (p) tick();
        end
        ser_rx = stop;
        repeat (p) tick();
        ser_rx = 1'b1;
        repeat (4) tick();
        if (stop) begin
            m_valid = 1'b1;
            m_byte  = b;
        end
        check("rx_data", reg_dat_do, exp_dat());
    endtask

    task automatic read_dat();
        reg_dat_re = 1'b1;
        tick();
        reg_dat_re = 1'b0;
        m_valid = 1'b0;
        check("rx_read_clear", reg_dat_do, exp_dat());
    endtask

    initial begin
        int first_low;
        int p;
        logic seen;
        logic [7:0] b;
        m_div   = 32'd16;
        m_valid = 1'b0;
        m_byte  = '0;

        // Reset state and the power-on dummy frame
        repeat (3) tick();
        rst = 1'b0;
        check("reset_div", reg_div_do, 32'd16);
        check("reset_dat", reg_dat_do, 32'hFFFF_FFFF);
        check("reset_tx", 32'(ser_tx), 32'd1);
        first_low = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (c == 5) begin
                reg_dat_we = 1'b1;
                reg_dat_di = 32'h0000_00C3;
                #1;
            end
            if (c >= 5 && !reg_dat_wait) begin
                first_low = c;
                break;
            end
        end
        check("dummy_len", 32'(first_low), 32'd160);
        check("dummy_line", 32'(ser_tx), 32'd1);
        tick();
        reg_dat_we = 1'b0;
        watch_tx({1'b1, 8'hC3, 1'b0});

        // Partial lane write of the divider
        write_div(4'b0001, 32'h1234_5608);
        check("div_lane0", reg_div_do, 32'h0000_0008);

        // TX of 0xA5 with a stalled second write
        send_byte(8'hA5);

        // RX, read, overrun
        rx_frame(8'h3C, 1'b1);
        read_dat();
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);

        // Completion of 0x33 while the host keeps reading
        p = per();
        ser_rx = 1'b0;
        repeat (p) tick();
        for (int i = 0; i < 8; i++) begin
            b = 8'h33;
            ser_rx = b[i];
            repeat (p) tick();
        end
        ser_rx = 1'b1;
        reg_dat_re = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < p + 8; c++) begin
            tick();
            if (reg_dat_do == 32'h0000_0033) begin
                seen = 1'b1;
                break;
            end
        end
        reg_dat_re = 1'b0;
        check("rx_coincident_seen", 32'(seen), 32'd1);
        m_valid = 1'b1;
        m_byte  = 8'h33;
        tick();
        check("rx_coincident_hold", reg_dat_do, exp_dat());
        repeat (p) tick();
        read_dat();

        // Glitch, framing error, then a good frame
        ser_rx = 1'b0;
        repeat (2) tick();
        ser_rx = 1'b1;
        repeat (3 * p) tick();
        check("rx_glitch", reg_dat_do, exp_dat());
        rx_frame(8'hF0, 1'b0);
        rx_frame(8'h5A, 1'b1);
        read_dat();

        // Random TX at random dividers, including clamped 0 and 1
        for (int n = 0; n < 6; n++) begin
            write_div(4'hF, $urandom_range(0, 12));
            send_byte(8'($urandom()));
        end

        // Random RX with random reads
        write_div(4'hF, $urandom_range(8, 14));
        for (int n = 0; n < 8; n++) begin
            rx_frame(8'($urandom()), 1'b1);
            if ($urandom_range(0, 1) == 1) read_dat();
        end

        // Reset in the middle of a TX frame with a byte buffered
        rx_frame(8'h77, 1'b1);
        reg_dat_we = 1'b1;
        reg_dat_di = 32'h0000_0000;
        tick();
        reg_dat_we = 1'b0;
        repeat (20) tick();
        check("mid_tx_low", 32'(ser_tx), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_div   = 32'd16;
        m_valid = 1'b0;
        check("rst_tx", 32'(ser_tx), 32'd1);
        check("rst_div", reg_div_do, 32'd16);
        check("rst_dat", reg_dat_do, exp_dat());
        watch_tx(10'h3FF);
        send_byte(8'h96);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
